logic_unit_acc: RTL and testbench
=================================

Name: logic_unit_acc

Overview:
- Parametrised, registered successor to the single-bit OR/NOR gate blocks.
- Applies one of eight bitwise operations to two WIDTH-bit operands per accepted beat.
- In pass-through mode, returns each result after one cycle.
- In accumulate mode, ORs the results of a multi-beat sequence together and emits one result with a beat count.
- Sits between a stimulus/control source and a consumer; both sides use valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).
- CNT_W, 8, width of the beat counter and out_count (≥1).

Ports:
- clk  input  1  single clock; everything is rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select.
- in_acc  input  1  beat belongs to an accumulate sequence.
- in_last  input  1  final beat of an accumulate sequence; ignored when in_acc=0.
- out_valid  output  1  result held in the output register.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  result.
- out_zero  output  1  out_data == 0.
- out_count  output  CNT_W  beats folded into out_data.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset, sampled at the clk edge: out_valid=0, out_data=0, out_zero=1, out_count=0, accumulator=0, beat counter=0.
  - Reset mid-sequence discards the partial accumulation.
  - No output is produced for a discarded sequence.
- Op codes (3 bits):
  - 0 OR, 1 NOR, 2 AND, 3 NAND
  - 4 XOR, 5 XNOR, 6 NOT A (in_b ignored), 7 PASS A
- Per-beat result: r = in_a op in_b, computed combinationally and bitwise.
- Handshakes:
  - in_ready = !out_valid || out_ready, combinational. The output register can be refilled in the same cycle it is drained.
  - A beat is accepted when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Once out_valid rises, out_data, out_zero and out_count stay stable until the transfer. No combinational path from in_* to out_*.
- Pass-through (in_acc=0), accepted beat:
  - Next cycle: out_valid=1, out_data=r, out_count=1.
  - Latency is exactly 1 cycle.
  - Accumulator and counter are untouched, so a pass-through beat may be interleaved inside an open sequence.
- Accumulate (in_acc=1, in_last=0), accepted beat:
  - acc <= acc | r; cnt <= cnt+1, saturating at 2^CNT_W-1.
  - No output change; out_valid keeps its current value and the pending transfer proceeds normally.
- Accumulate with in_last=1, accepted beat:
  - Next cycle: out_valid=1, out_data = acc | r, out_count = sat(cnt+1).
  - Same cycle: acc <= 0, cnt <= 0.
  - A one-beat sequence (in_acc=1, in_last=1, cnt=0) behaves like pass-through, with out_count=1.
- Op changes between beats of one sequence are legal; each beat uses its own in_op.
- If no beat is accepted and no output transfer occurs, all state holds.
- Simultaneous output transfer and new accepted beat: the output register loads the new result and out_valid stays 1. No bubble.
- Transfer with no new result: out_valid drops to 0; out_data and out_count hold their old values.
- out_zero is registered alongside out_data.

Decomposition:
- Package logic_unit_pkg:
  - op code localparams OP_OR … OP_PASS
  - op width constant (3)
- Sub-module bitwise_op (combinational; parameter WIDTH; ports a, b, op, r) implements the eight operations. Instantiated once.
- logic_unit_acc holds the accumulator, counter, output register and handshake logic.

Test Plan:
- Truth table: WIDTH=2 covers the per-bit truth table directly. All 8 ops × all 4 a/b pairs, each with out_ready=1 → each out_data matches the table one cycle after acceptance. Check op1 a=2'b00 b=2'b01 → 2'b10; op0 a=2'b01 b=2'b10 → 2'b11.
- Accumulate:
  - Inputs: in_acc=1, op0 beats (01,00), (00,04), last (10,00) with WIDTH=8.
  - Expected: exactly one output, out_data=0x15, out_count=3, no out_valid before the last beat.
- Backpressure:
  - Stimulus: hold out_ready=0 after one pass-through result (0xF0).
  - Expected: in_ready=0 and out_data stays 0xF0 for 5 cycles. Raising out_ready with a queued beat (op2 0xFF,0x0F) → 0x0F on the next cycle, with no bubble.
- Interleave:
  - Stimulus: pass-through beat (op4 0xAA,0xFF) inside an open sequence whose partial acc=0x01.
  - Expected: out_data=0x55, out_count=1. The sequence completes later, op0 last (0x02,0) → 0x03, count=2.
- Saturation:
  - Setup: CNT_W=2.
  - Stimulus: sequence of 6 beats.
  - Expected: out_count=3.
- Reset mid-sequence:
  - Stimulus: assert reset after 2 accumulate beats of 0x80, then send a one-beat sequence with last (0x01,0), op0.
  - Expected: out_data=0x01, out_count=1; reset-cycle outputs are out_valid=0 and out_zero=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared op-code definitions for the registered logic unit and its bitwise datapath.
// Op codes are fixed by the external control interface, so they are plain localparams.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_OR   = 3'd0;
    localparam op_t OP_NOR  = 3'd1;
    localparam op_t OP_AND  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOTA = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/bitwise_op.sv
// Combinational WIDTH-bit bitwise operator.
// Selects one of eight two-input logic functions applied per bit.
module bitwise_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        r = '0;
        case (op)
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_AND:  r = a & b;
            OP_NAND: r = ~(a & b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            OP_PASS: r = a;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_acc.sv
// Registered logic unit with optional multi-beat OR-accumulation and valid/ready on both sides.
// A single output register serves both pass-through and completed-sequence results.
module logic_unit_acc
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  op_t              in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             emit;
    logic             drain;
    logic [WIDTH-1:0] emit_data;
    logic [CNT_W-1:0] emit_count;

    bitwise_op #(.WIDTH(WIDTH)) u_op (
        .a  (in_a),
        .b  (in_b),
        .op (in_op),
        .r  (r)
    );

    // The output register can be refilled in the same cycle it is drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // A beat produces output when it is pass-through or closes a sequence.
    assign emit       = accept && (!in_acc || in_last);
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign emit_data  = in_acc ? (acc_q | r) : r;
    assign emit_count = in_acc ? cnt_inc : CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b1;
            out_count <= '0;
        end else begin
            // Pass-through beats leave the open sequence untouched.
            if (accept && in_acc) begin
                if (in_last) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_q | r;
                    cnt_q <= cnt_inc;
                end
            end

            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= emit_data;
                out_zero  <= (emit_data == '0);
                out_count <= emit_count;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_acc.sv
// Directed self-checking bench: three instances cover WIDTH=8, WIDTH=2 truth table, CNT_W=2 saturation.
module tb_logic_unit_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Main instance, WIDTH=8, CNT_W=8
    logic       reset, in_valid, in_acc, in_last, out_ready;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;
    logic       in_ready, out_valid, out_zero;
    logic [7:0] out_data, out_count;

    logic_unit_acc #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_count(out_count)
    );

    // Truth-table instance, WIDTH=2
    logic       t_in_valid, t_in_acc, t_in_last, t_out_ready;
    logic [1:0] t_in_a, t_in_b;
    logic [2:0] t_in_op;
    logic       t_in_ready, t_out_valid, t_out_zero;
    logic [1:0] t_out_data;
    logic [7:0] t_out_count;

    logic_unit_acc #(.WIDTH(2), .CNT_W(8)) dut_w2 (
        .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_a(t_in_a), .in_b(t_in_b), .in_op(t_in_op), .in_acc(t_in_acc), .in_last(t_in_last),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
        .out_zero(t_out_zero), .out_count(t_out_count)
    );

    // Saturation instance, CNT_W=2
    logic       s_in_valid, s_in_acc, s_in_last, s_out_ready;
    logic [7:0] s_in_a, s_in_b;
    logic [2:0] s_in_op;
    logic       s_in_ready, s_out_valid, s_out_zero;
    logic [7:0] s_out_data;
    logic [1:0] s_out_count;

    logic_unit_acc #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_acc(s_in_acc), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_zero(s_out_zero), .out_count(s_out_count)
    );

    // Per-op truth table indexed by {a_bit, b_bit}
    logic [3:0] tt [0:7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat on the main instance for a single edge, then withdraw it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic acc, input logic last);
        in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic flush();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        tests_run++; if (out_zero !== 1'b1) begin tests_failed++; $display("FAIL reset_zero: got %b expected 1", out_zero); end
        tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", out_data); end
        tests_run++; if (out_count !== 8'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (t_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_w2_valid: got %b expected 0", t_out_valid); end
        tests_run++; if (s_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_sat_valid: got %b expected 0", s_out_valid); end
        reset = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [1:0] a, b, exp;
        t_out_ready = 1'b1; t_in_acc = 1'b0; t_in_last = 1'b0;
        for (int op = 0; op < 8; op++) begin
            for (int ai = 0; ai < 4; ai++) begin
                for (int bi = 0; bi < 4; bi++) begin
                    a = 2'(ai); b = 2'(bi);
                    for (int i = 0; i < 2; i++) exp[i] = tt[op][{a[i], b[i]}];
                    t_in_a = a; t_in_b = b; t_in_op = 3'(op); t_in_valid = 1'b1;
                    step();
                    tests_run++;
                    if (t_out_valid !== 1'b1 || t_out_data !== exp || t_out_zero !== (exp == 2'b00)
                        || t_out_count !== 8'd1) begin
                        tests_failed++;
                        $display("FAIL truth op%0d a=%b b=%b: got v=%b d=%b z=%b c=%0d expected v=1 d=%b z=%b c=1",
                                 op, a, b, t_out_valid, t_out_data, t_out_zero, t_out_count, exp, exp == 2'b00);
                    end
                end
            end
        end
        // Spot vectors called out explicitly
        t_in_a = 2'b00; t_in_b = 2'b01; t_in_op = 3'd1;
        step();
        tests_run++; if (t_out_data !== 2'b10) begin tests_failed++; $display("FAIL truth_nor_spot: got %b expected 10", t_out_data); end
        t_in_a = 2'b01; t_in_b = 2'b10; t_in_op = 3'd0;
        step();
        tests_run++; if (t_out_data !== 2'b11) begin tests_failed++; $display("FAIL truth_or_spot: got %b expected 11", t_out_data); end
        t_in_valid = 1'b0;
        step();
        tests_run++; if (t_out_valid !== 1'b0) begin tests_failed++; $display("FAIL truth_drain: got %b expected 0", t_out_valid); end
    endtask

    task automatic test_accumulate();
        flush();
        send(8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL acc_beat1_valid: got %b expected 0", out_valid); end
        send(8'h00, 8'h04, 3'd0, 1'b1, 1'b0);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL acc_beat2_valid: got %b expected 0", out_valid); end
        send(8'h10, 8'h00, 3'd0, 1'b1, 1'b1);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL acc_last_valid: got %b expected 1", out_valid); end
        tests_run++; if (out_data !== 8'h15) begin tests_failed++; $display("FAIL acc_data: got %h expected 15", out_data); end
        tests_run++; if (out_count !== 8'd3) begin tests_failed++; $display("FAIL acc_count: got %0d expected 3", out_count); end
        tests_run++; if (out_zero !== 1'b0) begin tests_failed++; $display("FAIL acc_zero: got %b expected 0", out_zero); end
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL acc_single_output: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        flush();
        out_ready = 1'b0;
        send(8'hF0, 8'h00, 3'd7, 1'b0, 1'b0);
        tests_run++; if (out_data !== 8'hF0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_first: got v=%b d=%h expected v=1 d=f0", out_valid, out_data); end
        in_a = 8'hFF; in_b = 8'h0F; in_op = 3'd2; in_acc = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", i, in_ready); end
            step();
            tests_run++; if (out_data !== 8'hF0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold cyc%0d: got v=%b d=%h expected v=1 d=f0", i, out_valid, out_data); end
        end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin tests_failed++; $display("FAIL bp_no_bubble: got v=%b d=%h expected v=1 d=0f", out_valid, out_data); end
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_interleave();
        flush();
        send(8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL il_open_valid: got %b expected 0", out_valid); end
        send(8'hAA, 8'hFF, 3'd4, 1'b0, 1'b0);
        tests_run++; if (out_data !== 8'h55 || out_count !== 8'd1) begin tests_failed++; $display("FAIL il_pass: got d=%h c=%0d expected d=55 c=1", out_data, out_count); end
        send(8'h02, 8'h00, 3'd0, 1'b1, 1'b1);
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h03 || out_count !== 8'd2) begin tests_failed++; $display("FAIL il_close: got v=%b d=%h c=%0d expected v=1 d=03 c=2", out_valid, out_data, out_count); end
    endtask

    task automatic test_back_to_back();
        flush();
        in_acc = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        in_a = 8'h0F; in_b = 8'h0F; in_op = 3'd5;
        step();
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_zero !== 1'b0) begin tests_failed++; $display("FAIL b2b_xnor: got v=%b d=%h z=%b expected v=1 d=ff z=0", out_valid, out_data, out_zero); end
        in_a = 8'hFF; in_b = 8'h12; in_op = 3'd6;
        step();
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_zero !== 1'b1) begin tests_failed++; $display("FAIL b2b_nota: got v=%b d=%h z=%b expected v=1 d=00 z=1", out_valid, out_data, out_zero); end
        in_a = 8'hF3; in_b = 8'h3C; in_op = 3'd3;
        step();
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'hCF) begin tests_failed++; $display("FAIL b2b_nand: got v=%b d=%h expected v=1 d=cf", out_valid, out_data); end
        in_a = 8'h50; in_b = 8'h0A; in_op = 3'd1;
        step();
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin tests_failed++; $display("FAIL b2b_nor: got v=%b d=%h expected v=1 d=a5", out_valid, out_data); end
        in_a = 8'h5A; in_b = 8'hFF; in_op = 3'd7;
        step();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin tests_failed++; $display("FAIL b2b_pass: got v=%b d=%h expected v=1 d=5a", out_valid, out_data); end
        step();
        tests_run++; if (out_valid !== 1'b0 || out_data !== 8'h5A || out_count !== 8'd1) begin tests_failed++; $display("FAIL b2b_hold_after_drain: got v=%b d=%h c=%0d expected v=0 d=5a c=1", out_valid, out_data, out_count); end
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b1; s_in_op = 3'd0; s_in_b = 8'h00; s_in_acc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_in_a = 8'(1 << i); s_in_last = (i == 5); s_in_valid = 1'b1;
            step();
            if (i < 5) begin
                tests_run++; if (s_out_valid !== 1'b0) begin tests_failed++; $display("FAIL sat_beat%0d_valid: got %b expected 0", i, s_out_valid); end
            end
        end
        s_in_valid = 1'b0;
        tests_run++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h3F || s_out_count !== 2'd3) begin tests_failed++; $display("FAIL sat_result: got v=%b d=%h c=%0d expected v=1 d=3f c=3", s_out_valid, s_out_data, s_out_count); end
    endtask

    task automatic test_reset_mid();
        flush();
        send(8'h80, 8'h00, 3'd0, 1'b1, 1'b0);
        send(8'h80, 8'h00, 3'd0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        tests_run++; if (out_valid !== 1'b0 || out_zero !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_outputs: got v=%b z=%b expected v=0 z=1", out_valid, out_zero); end
        reset = 1'b0;
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_output: got %b expected 0", out_valid); end
        send(8'h01, 8'h00, 3'd0, 1'b1, 1'b1);
        tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_count !== 8'd1) begin tests_failed++; $display("FAIL rst_mid_fresh: got v=%b d=%h c=%0d expected v=1 d=01 c=1", out_valid, out_data, out_count); end
    endtask

    initial begin
        tt[0] = 4'b1110; tt[1] = 4'b0001; tt[2] = 4'b1000; tt[3] = 4'b0111;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;

        reset = 1'b1; in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0;
        t_in_valid = 1'b0; t_in_acc = 1'b0; t_in_last = 1'b0; t_out_ready = 1'b1;
        t_in_a = '0; t_in_b = '0; t_in_op = '0;
        s_in_valid = 1'b0; s_in_acc = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b1;
        s_in_a = '0; s_in_b = '0; s_in_op = '0;

        test_reset();
        test_truth_table();
        test_accumulate();
        test_backpressure();
        test_interleave();
        test_back_to_back();
        test_saturation();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
